// File: rtl/hex_display_scanner_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package hex_display_scanner_pkg;

  localparam int unsigned DEF_DIGITS = 4;
  localparam int unsigned DEF_DIV    = 50000;
  localparam int unsigned NIBBLE_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_display_scanner_scan_tick_gen.sv
// Digit-slot prescaler: counts 0..DIV-1 while enabled, tick on the last count.
module scan_tick_gen
  import hex_display_scanner_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned      CNT_W   = cnt_width(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == CNT_MAX) begin
        tick = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Scans a DIGITS-wide hex value onto a shared nibble bus with active-low anodes;
// new values are double-buffered and committed only at frame boundaries.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int unsigned DIGITS   = DEF_DIGITS,
  parameter int unsigned DIV      = DEF_DIV,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [NIBBLE_W*DIGITS-1:0]   load_data,
  output logic [NIBBLE_W-1:0]          nibble,
  output logic [DIGITS-1:0]            an,
  output logic                         blank,
  output logic                         frame_done
);

  localparam int unsigned       IDX_W     = cnt_width(DIGITS);
  localparam int unsigned       DATA_W    = NIBBLE_W * DIGITS;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODE_OFF = '1;

  scan_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    disp_q, disp_d;
  logic [DATA_W-1:0]    pend_q, pend_d;
  logic                 pend_v_q, pend_v_d;
  logic [NIBBLE_W-1:0]  nibble_q, nibble_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic                 blank_q, blank_d;
  logic                 frame_done_q, frame_done_d;

  logic tick;
  logic commit;
  logic accept;
  logic upper_nz;

  scan_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_SCAN),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    commit       = 1'b0;
    frame_done_d = 1'b0;
    nibble_d     = '0;
    an_d         = ANODE_OFF;
    blank_d      = 1'b1;
    upper_nz     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_v_q) begin
          commit  = 1'b1;
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            commit       = pend_v_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end

    // The committing cycle frees the buffer, so a held load slips in behind it.
    load_ready = !rst && (!pend_v_q || commit);
    accept     = load_valid && load_ready;
    if (accept) begin
      pend_d   = load_data;
      pend_v_d = 1'b1;
    end

    if (state_d == ST_SCAN) begin
      nibble_d = disp_d[NIBBLE_W*idx_d +: NIBBLE_W];
      an_d     = ~(DIGITS'(1) << idx_d);
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if ((i >= 32'(idx_d)) && (disp_d[NIBBLE_W*i +: NIBBLE_W] != '0)) begin
          upper_nz = 1'b1;
        end
      end
      blank_d = LZ_BLANK && (idx_d != '0) && !upper_nz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      nibble_q     <= '0;
      an_q         <= ANODE_OFF;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      nibble_q     <= nibble_d;
      an_q         <= an_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble     = nibble_q;
  assign an         = an_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: three instances cover DIV=4 with and
// without leading-zero blanking, and DIV=1.
module tb_hex_display_scanner;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
  logic [15:0] a_data = '0, b_data = '0, c_data = '0;
  logic        a_ready, b_ready, c_ready;
  logic [3:0]  a_nib, b_nib, c_nib;
  logic [3:0]  a_an, b_an, c_an;
  logic        a_blank, b_blank, c_blank;
  logic        a_fd, b_fd, c_fd;

  int checks   = 0;
  int failures = 0;
  int fd_cnt_a = 0;
  int fd_cnt_c = 0;
  int fd_a0, fd_c0;

  always #5 clk = ~clk;

  hex_display_scanner #(.DIGITS(4), .DIV(4), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .load_valid(a_valid), .load_ready(a_ready),
    .load_data(a_data), .nibble(a_nib), .an(a_an), .blank(a_blank),
    .frame_done(a_fd));

  hex_display_scanner #(.DIGITS(4), .DIV(4), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .load_valid(b_valid), .load_ready(b_ready),
    .load_data(b_data), .nibble(b_nib), .an(b_an), .blank(b_blank),
    .frame_done(b_fd));

  hex_display_scanner #(.DIGITS(4), .DIV(1), .LZ_BLANK(1'b1)) dut_c (
    .clk(clk), .rst(rst), .load_valid(c_valid), .load_ready(c_ready),
    .load_data(c_data), .nibble(c_nib), .an(c_an), .blank(c_blank),
    .frame_done(c_fd));

  always @(negedge clk) begin
    if (a_fd === 1'b1) fd_cnt_a++;
    if (c_fd === 1'b1) fd_cnt_c++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset asserted mid-cycle acts immediately.
    #12 rst = 1'b1;
    #1;
    chk("rst_an", 32'(a_an), 32'h0000000F);
    chk("rst_blank", 32'(a_blank), 32'h1);
    chk("rst_nibble", 32'(a_nib), 32'h0);
    chk("rst_ready", 32'(a_ready), 32'h0);
    chk("rst_fd", 32'(a_fd), 32'h0);
    step(2);
    rst = 1'b0;
    #1;
    chk("idle_an", 32'(a_an), 32'h0000000F);
    chk("idle_blank", 32'(a_blank), 32'h1);
    chk("idle_nibble", 32'(a_nib), 32'h0);
    chk("idle_ready", 32'(a_ready), 32'h1);

    // Load from IDLE: accepted at E0, committed at E1.
    a_valid = 1'b1; a_data = 16'h12AF;
    b_valid = 1'b1; b_data = 16'h0000;
    c_valid = 1'b1; c_data = 16'h12AF;
    step(1);
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    chk("e0_an_still_off", 32'(a_an), 32'h0000000F);
    step(1);
    chk("f0_d0_an", 32'(a_an), 32'h0000000E);
    chk("f0_d0_nib", 32'(a_nib), 32'hF);
    chk("f0_d0_blank", 32'(a_blank), 32'h0);
    chk("f0_d0_fd", 32'(a_fd), 32'h0);
    chk("b_d0_an", 32'(b_an), 32'h0000000E);
    chk("b_d0_blank", 32'(b_blank), 32'h0);
    chk("c_d0_an", 32'(c_an), 32'h0000000E);
    chk("c_d0_nib", 32'(c_nib), 32'hF);
    fd_a0 = fd_cnt_a;
    fd_c0 = fd_cnt_c;

    // DIV=1 advances every cycle while DIV=4 holds its slot.
    step(1);
    chk("c_d1_an", 32'(c_an), 32'h0000000D);
    chk("c_d1_nib", 32'(c_nib), 32'hA);
    step(1);
    chk("c_d2_an", 32'(c_an), 32'h0000000B);
    chk("c_d2_nib", 32'(c_nib), 32'h2);
    step(1);
    chk("c_d3_an", 32'(c_an), 32'h00000007);
    chk("c_d3_nib", 32'(c_nib), 32'h1);
    chk("a_slot0_held", 32'(a_an), 32'h0000000E);
    step(1);
    chk("c_wrap_an", 32'(c_an), 32'h0000000E);
    chk("c_wrap_fd", 32'(c_fd), 32'h1);
    chk("f0_d1_an", 32'(a_an), 32'h0000000D);
    chk("f0_d1_nib", 32'(a_nib), 32'hA);
    chk("f0_d1_blank", 32'(a_blank), 32'h0);
    chk("b_d1_blank", 32'(b_blank), 32'h0);
    step(4);
    chk("f0_d2_an", 32'(a_an), 32'h0000000B);
    chk("f0_d2_nib", 32'(a_nib), 32'h2);
    chk("b_d2_blank", 32'(b_blank), 32'h0);
    step(4);
    chk("f0_d3_an", 32'(a_an), 32'h00000007);
    chk("f0_d3_nib", 32'(a_nib), 32'h1);
    chk("b_d3_blank", 32'(b_blank), 32'h0);
    step(4);
    chk("f1_d0_an", 32'(a_an), 32'h0000000E);
    chk("f1_d0_nib", 32'(a_nib), 32'hF);
    chk("f1_fd_pulse", 32'(a_fd), 32'h1);
    step(1);
    chk("f1_fd_drop", 32'(a_fd), 32'h0);
    chk("a_fd_count", 32'(fd_cnt_a - fd_a0), 32'h1);
    chk("c_fd_count", 32'(fd_cnt_c - fd_c0), 32'h4);

    // Mid-frame load of BEEF, then C0DE held on valid.
    step(3);
    chk("f1_d1_an", 32'(a_an), 32'h0000000D);
    chk("ready_empty", 32'(a_ready), 32'h1);
    a_valid = 1'b1; a_data = 16'hBEEF;
    step(1);
    a_data = 16'hC0DE;
    chk("ready_full", 32'(a_ready), 32'h0);
    step(3);
    chk("f1_d2_old_nib", 32'(a_nib), 32'h2);
    chk("f1_d2_ready", 32'(a_ready), 32'h0);
    step(4);
    chk("f1_d3_old_nib", 32'(a_nib), 32'h1);
    step(3);
    chk("ready_commit", 32'(a_ready), 32'h1);
    step(1);
    a_valid = 1'b0;
    chk("f2_d0_an", 32'(a_an), 32'h0000000E);
    chk("f2_d0_nib", 32'(a_nib), 32'hF);
    chk("f2_ready", 32'(a_ready), 32'h0);
    step(4);
    chk("f2_d1_nib", 32'(a_nib), 32'hE);
    step(4);
    chk("f2_d2_nib", 32'(a_nib), 32'hE);
    step(4);
    chk("f2_d3_nib", 32'(a_nib), 32'hB);
    step(4);
    chk("f3_d0_nib", 32'(a_nib), 32'hE);
    step(4);
    chk("f3_d1_nib", 32'(a_nib), 32'hD);
    chk("f3_ready", 32'(a_ready), 32'h1);

    // Reset during SCAN with a pending value discards it.
    a_valid = 1'b1; a_data = 16'h5A5A;
    step(1);
    a_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("rst2_an", 32'(a_an), 32'h0000000F);
    chk("rst2_blank", 32'(a_blank), 32'h1);
    chk("rst2_nibble", 32'(a_nib), 32'h0);
    chk("rst2_c_an", 32'(c_an), 32'h0000000F);
    step(1);
    rst = 1'b0;
    step(10);
    chk("post_rst_idle_an", 32'(a_an), 32'h0000000F);
    chk("post_rst_blank", 32'(a_blank), 32'h1);
    chk("post_rst_ready", 32'(a_ready), 32'h1);

    // Leading-zero blanking.
    a_valid = 1'b1; a_data = 16'h0050;
    step(1);
    a_valid = 1'b0;
    step(1);
    chk("lz_d0_nib", 32'(a_nib), 32'h0);
    chk("lz_d0_blank", 32'(a_blank), 32'h0);
    step(4);
    chk("lz_d1_nib", 32'(a_nib), 32'h5);
    chk("lz_d1_blank", 32'(a_blank), 32'h0);
    step(4);
    chk("lz_d2_blank", 32'(a_blank), 32'h1);
    step(4);
    chk("lz_d3_an", 32'(a_an), 32'h00000007);
    chk("lz_d3_blank", 32'(a_blank), 32'h1);
    a_valid = 1'b1; a_data = 16'h0000;
    step(1);
    a_valid = 1'b0;
    step(3);
    chk("z_d0_an", 32'(a_an), 32'h0000000E);
    chk("z_d0_nib", 32'(a_nib), 32'h0);
    chk("z_d0_blank", 32'(a_blank), 32'h0);
    step(4);
    chk("z_d1_blank", 32'(a_blank), 32'h1);
    step(4);
    chk("z_d2_blank", 32'(a_blank), 32'h1);
    step(4);
    chk("z_d3_blank", 32'(a_blank), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
